mat4_dot_sequencer: RTL and testbench

- Initiator side of the dot-product engine interface (start / vec_a / vec_b / result / done).
- Accepts one 4x4 matrix job (A, B; 32-bit unsigned elements), issues 16 row-by-column dot products to a single engine, assembles C = A x B, and presents C on a valid/ready output.
- Sits between the AFU job buffer and the dot-product engine in the 4x4 multiply datapath.

---
 rtl/mat4_pkg.sv | 43 ++++
 rtl/mat4_vec_select.sv | 19 +
 rtl/mat4_dot_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_mat4_dot_sequencer.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mat4_pkg.sv
// Purpose : shared widths, sequencer state encoding and row/column gather helpers
//           for the 4x4 matrix multiply datapath.
// Latency : n/a (types and pure functions only).
// Backpr. : n/a.
package mat4_pkg;

    localparam int ELEM_W = 32;
    localparam int DIM    = 4;
    localparam int VEC_W  = ELEM_W * DIM;   // 128
    localparam int MAT_W  = VEC_W * DIM;    // 512

    typedef enum logic [2:0] {
        ST_CLR0  = 3'd0,   // post-reset engine clear
        ST_IDLE  = 3'd1,   // waiting for a job
        ST_ISSUE = 3'd2,   // present vectors, raise dp_start
        ST_WAIT  = 3'd3,   // wait for dp_done or timeout
        ST_CLR   = 3'd4,   // engine clear between dot products
        ST_OUT   = 3'd5    // present C until consumed
    } state_t;

    // Row i of a row-major matrix; lane k = M(i,k).
    function automatic logic [VEC_W-1:0] get_row(input logic [MAT_W-1:0] mat,
                                                 input logic [1:0]       i);
        logic [VEC_W-1:0] v;
        v = '0;
        for (int k = 0; k < DIM; k++) begin
            v[ELEM_W*k +: ELEM_W] = mat[ELEM_W*(DIM*int'(i) + k) +: ELEM_W];
        end
        return v;
    endfunction

    // Column j of a row-major matrix; lane k = M(k,j).
    function automatic logic [VEC_W-1:0] get_col(input logic [MAT_W-1:0] mat,
                                                 input logic [1:0]       j);
        logic [VEC_W-1:0] v;
        v = '0;
        for (int k = 0; k < DIM; k++) begin
            v[ELEM_W*k +: ELEM_W] = mat[ELEM_W*(DIM*k + int'(j)) +: ELEM_W];
        end
        return v;
    endfunction

endpackage

// File: rtl/mat4_vec_select.sv
// Purpose : combinational gather of row A(i,*) and column B(*,j) for idx = {i,j}.
// Latency : 0 cycles (pure combinational; the parent registers the result).
// Backpr. : none.
// Ports   : i_a_mat/i_b_mat latched matrices, i_idx dot-product index,
//           o_vec_a row of A, o_vec_b column of B.
module mat4_vec_select
    import mat4_pkg::*;
(
    input  logic [MAT_W-1:0] i_a_mat,
    input  logic [MAT_W-1:0] i_b_mat,
    input  logic [3:0]       i_idx,
    output logic [VEC_W-1:0] o_vec_a,
    output logic [VEC_W-1:0] o_vec_b
);

    assign o_vec_a = get_row(i_a_mat, i_idx[3:2]);
    assign o_vec_b = get_col(i_b_mat, i_idx[1:0]);

endmodule

// File: rtl/mat4_dot_sequencer.sv
// Purpose : accepts one A/B job, drives 16 row-by-column dot products through a
//           single engine and returns C = A x B on a valid/ready port.
// Latency : job accept to c_valid = 16*(D+2)+1 cycles for engine delay D, CLR_CYCLES=1.
// Backpr. : job_ready only in IDLE; C held stable until c_ready.
// Ports   : clk/reset; job_valid/job_ready/a_matrix/b_matrix job input;
//           dp_start/dp_vec_a/dp_vec_b/dp_result/dp_done/dp_clr engine side;
//           c_matrix/c_valid/c_ready/c_error result output.
module mat4_dot_sequencer
    import mat4_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CLR_CYCLES     = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             job_valid,
    output logic             job_ready,
    input  logic [MAT_W-1:0] a_matrix,
    input  logic [MAT_W-1:0] b_matrix,
    output logic             dp_start,
    output logic [VEC_W-1:0] dp_vec_a,
    output logic [VEC_W-1:0] dp_vec_b,
    input  logic [ELEM_W-1:0] dp_result,
    input  logic             dp_done,
    output logic             dp_clr,
    output logic [MAT_W-1:0] c_matrix,
    output logic             c_valid,
    input  logic             c_ready,
    output logic             c_error
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam int CW = $clog2(CLR_CYCLES + 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] CLR_LAST     = CW'(CLR_CYCLES);

    state_t            r_state;
    logic [MAT_W-1:0]  r_a;
    logic [MAT_W-1:0]  r_b;
    logic [MAT_W-1:0]  r_c;
    logic [3:0]        r_idx;
    logic [TW-1:0]     r_timer;
    logic [CW-1:0]     r_clr_cnt;   // cycles dp_clr has been high so far
    logic              r_err;
    logic              r_abort;
    logic              r_job_ready;
    logic              r_dp_start;
    logic              r_dp_clr;
    logic [VEC_W-1:0]  r_vec_a;
    logic [VEC_W-1:0]  r_vec_b;
    logic              r_c_valid;
    logic              r_c_error;

    logic [VEC_W-1:0]  w_vec_a;
    logic [VEC_W-1:0]  w_vec_b;

    mat4_vec_select u_vec_select (
        .i_a_mat (r_a),
        .i_b_mat (r_b),
        .i_idx   (r_idx),
        .o_vec_a (w_vec_a),
        .o_vec_b (w_vec_b)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_CLR0;
            r_a         <= '0;
            r_b         <= '0;
            r_c         <= '0;
            r_idx       <= '0;
            r_timer     <= '0;
            r_clr_cnt   <= '0;
            r_err       <= 1'b0;
            r_abort     <= 1'b0;
            r_job_ready <= 1'b0;
            r_dp_start  <= 1'b0;
            r_dp_clr    <= 1'b0;
            r_vec_a     <= '0;
            r_vec_b     <= '0;
            r_c_valid   <= 1'b0;
            r_c_error   <= 1'b0;
        end else begin
            case (r_state)
                // dp_clr is still low on the first cycle out of reset, so the
                // pulse starts one cycle later and runs for CLR_CYCLES.
                ST_CLR0: begin
                    if (r_dp_clr && (r_clr_cnt == CLR_LAST)) begin
                        r_dp_clr    <= 1'b0;
                        r_clr_cnt   <= '0;
                        r_job_ready <= 1'b1;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_dp_clr  <= 1'b1;
                        r_clr_cnt <= r_clr_cnt + CW'(1);
                    end
                end

                ST_IDLE: begin
                    if (job_valid) begin
                        r_a         <= a_matrix;
                        r_b         <= b_matrix;
                        r_idx       <= '0;
                        r_c         <= '0;
                        r_err       <= 1'b0;
                        r_abort     <= 1'b0;
                        r_job_ready <= 1'b0;
                        r_state     <= ST_ISSUE;
                    end
                end

                ST_ISSUE: begin
                    r_vec_a    <= w_vec_a;
                    r_vec_b    <= w_vec_b;
                    r_dp_start <= 1'b1;
                    r_timer    <= '0;
                    r_state    <= ST_WAIT;
                end

                // done is checked before the timer so a coincident done wins.
                ST_WAIT: begin
                    if (dp_done) begin
                        r_c[ELEM_W*r_idx +: ELEM_W] <= dp_result;
                        r_dp_start <= 1'b0;
                        r_dp_clr   <= 1'b1;
                        r_clr_cnt  <= CW'(1);
                        r_state    <= ST_CLR;
                    end else if (r_timer == TIMEOUT_LAST) begin
                        r_err      <= 1'b1;
                        r_abort    <= 1'b1;
                        r_dp_start <= 1'b0;
                        r_dp_clr   <= 1'b1;
                        r_clr_cnt  <= CW'(1);
                        r_state    <= ST_CLR;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end

                ST_CLR: begin
                    if (r_clr_cnt == CLR_LAST) begin
                        r_dp_clr  <= 1'b0;
                        r_clr_cnt <= '0;
                        if (r_abort || (r_idx == 4'd15)) begin
                            r_c_valid <= 1'b1;
                            r_c_error <= r_err;
                            r_state   <= ST_OUT;
                        end else begin
                            r_idx   <= r_idx + 4'd1;
                            r_state <= ST_ISSUE;
                        end
                    end else begin
                        r_clr_cnt <= r_clr_cnt + CW'(1);
                    end
                end

                ST_OUT: begin
                    if (c_ready) begin
                        r_c_valid   <= 1'b0;
                        r_c_error   <= 1'b0;
                        r_job_ready <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end

                default: begin
                    r_state <= ST_CLR0;
                end
            endcase
        end
    end

    assign job_ready = r_job_ready;
    assign dp_start  = r_dp_start;
    assign dp_clr    = r_dp_clr;
    assign dp_vec_a  = r_vec_a;
    assign dp_vec_b  = r_vec_b;
    assign c_matrix  = r_c;
    assign c_valid   = r_c_valid;
    assign c_error   = r_c_error;

endmodule

// File: tb/tb_mat4_dot_sequencer.sv
// Purpose : directed bench for mat4_dot_sequencer with a behavioural dot engine.
// Latency : engine answers eng_d cycles after dp_start; done held until dp_clr.
// Backpr. : bench drives job/c_ready handshakes directly.
module tb_mat4_dot_sequencer;

    logic         clk = 1'b0;
    logic         reset;
    logic         job_valid;
    logic         job_ready;
    logic [511:0] a_matrix;
    logic [511:0] b_matrix;
    logic         dp_start;
    logic [127:0] dp_vec_a;
    logic [127:0] dp_vec_b;
    logic [31:0]  dp_result = '0;
    logic         dp_done   = 1'b0;
    logic         dp_clr;
    logic [511:0] c_matrix;
    logic         c_valid;
    logic         c_ready;
    logic         c_error;

    int n_chk  = 0;
    int n_pass = 0;

    // engine model controls (written by the stimulus process only)
    int eng_d    = 3;
    int hang_idx = -1;

    // engine model state (written by the engine process only)
    int eng_cnt   = 0;
    int eng_idx   = 0;
    int job_dp    = 0;
    int n_start   = 0;
    int n_clr     = 0;
    bit prev_start = 1'b0;
    bit prev_clr   = 1'b0;

    always #5 clk = ~clk;

    mat4_dot_sequencer #(
        .TIMEOUT_CYCLES (64),
        .CLR_CYCLES     (1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .job_valid (job_valid),
        .job_ready (job_ready),
        .a_matrix  (a_matrix),
        .b_matrix  (b_matrix),
        .dp_start  (dp_start),
        .dp_vec_a  (dp_vec_a),
        .dp_vec_b  (dp_vec_b),
        .dp_result (dp_result),
        .dp_done   (dp_done),
        .dp_clr    (dp_clr),
        .c_matrix  (c_matrix),
        .c_valid   (c_valid),
        .c_ready   (c_ready),
        .c_error   (c_error)
    );

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] dot4(input logic [127:0] a, input logic [127:0] b);
        logic [31:0] s;
        s = '0;
        for (int k = 0; k < 4; k++) s = s + a[32*k +: 32] * b[32*k +: 32];
        return s;
    endfunction

    function automatic logic [511:0] mat_fill(input logic [31:0] v);
        logic [511:0] m;
        for (int e = 0; e < 16; e++) m[32*e +: 32] = v;
        return m;
    endfunction

    function automatic logic [511:0] mat_seq();
        logic [511:0] m;
        for (int e = 0; e < 16; e++) m[32*e +: 32] = 32'(e + 1);
        return m;
    endfunction

    function automatic logic [511:0] mat_ident();
        logic [511:0] m;
        m = '0;
        for (int i = 0; i < 4; i++) m[32*(5*i) +: 32] = 32'd1;
        return m;
    endfunction

    // Behavioural engine, evaluated on the falling edge so it never races the DUT.
    always @(negedge clk) begin
        if (reset) begin
            eng_cnt    = 0;
            dp_done    = 1'b0;
            dp_result  = '0;
            prev_start = 1'b0;
            prev_clr   = 1'b0;
        end else begin
            if (job_valid && job_ready) job_dp = 0;
            if (dp_clr && !prev_clr) n_clr++;
            if (dp_start && !prev_start) begin
                n_start++;
                eng_idx = job_dp;
                job_dp++;
                eng_cnt = 0;
            end
            prev_start = dp_start;
            prev_clr   = dp_clr;
            if (dp_clr) begin
                eng_cnt = 0;
                dp_done = 1'b0;
            end else if (dp_start && !dp_done) begin
                eng_cnt++;
                if (eng_cnt == eng_d && eng_idx != hang_idx) begin
                    dp_done   = 1'b1;
                    dp_result = dot4(dp_vec_a, dp_vec_b);
                end
            end
        end
    end

    task automatic wait_ready(input string tag, input bit want_clr);
        bit ok;
        bit seen_clr;
        ok = 1'b0;
        seen_clr = 1'b0;
        for (int t = 0; t < 200; t++) begin
            if (dp_clr) seen_clr = 1'b1;
            if (job_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        chk({tag, "_ready"}, 512'(ok), 512'(1));
        if (want_clr) chk({tag, "_clr_before_ready"}, 512'(seen_clr), 512'(1));
    endtask

    task automatic start_job(input string tag, input logic [511:0] a, input logic [511:0] b);
        wait_ready(tag, 1'b0);
        a_matrix  = a;
        b_matrix  = b;
        job_valid = 1'b1;
        @(posedge clk); #1;
        job_valid = 1'b0;
        // later changes to A/B must not reach the result
        a_matrix  = ~a;
        b_matrix  = ~b;
        chk({tag, "_accepted"}, 512'(job_ready), 512'(0));
    endtask

    task automatic finish_job(input string tag, input logic [511:0] exp_c,
                              input logic exp_err, input int exp_lat);
        int  n;
        bit  ok;
        n  = 0;
        ok = 1'b0;
        for (int t = 0; t < 3000; t++) begin
            @(posedge clk); #1;
            n++;
            if (c_valid) begin
                ok = 1'b1;
                break;
            end
        end
        chk({tag, "_cvalid"}, 512'(ok), 512'(1));
        // +1 counts the accept cycle itself
        if (exp_lat != 0) chk({tag, "_latency"}, 512'(n + 1), 512'(exp_lat));
        chk({tag, "_cmatrix"}, c_matrix, exp_c);
        chk({tag, "_cerror"}, 512'(c_error), 512'(exp_err));
        c_ready = 1'b1;
        @(posedge clk); #1;
        c_ready = 1'b0;
        chk({tag, "_cvalid_drop"}, 512'(c_valid), 512'(0));
        chk({tag, "_ready_after"}, 512'(job_ready), 512'(1));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [511:0] e;
        logic [511:0] a;
        logic [511:0] cm;
        int  s0, c0;
        bit  jr_bad, stable_bad, ok;

        reset     = 1'b1;
        job_valid = 1'b0;
        c_ready   = 1'b0;
        a_matrix  = '0;
        b_matrix  = '0;
        #12;
        chk("rst_ctrl", 512'({job_ready, dp_start, dp_clr, c_valid, c_error}), 512'(0));
        chk("rst_cmat", c_matrix, '0);
        chk("rst_vecs", 512'({dp_vec_a, dp_vec_b}), '0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        wait_ready("boot", 1'b1);

        // identity x (1..16) = (1..16), engine delay 3
        eng_d = 3;
        start_job("ident", mat_ident(), mat_seq());
        finish_job("ident", mat_seq(), 1'b0, 81);

        // all 2 x all 3 -> 24 everywhere; 16 starts and 16 clears
        s0 = n_start;
        c0 = n_clr;
        start_job("twos", mat_fill(32'd2), mat_fill(32'd3));
        finish_job("twos", mat_fill(32'd24), 1'b0, 81);
        chk("twos_starts", 512'(n_start - s0), 512'(16));
        chk("twos_clrs",   512'(n_clr - c0),   512'(16));

        // 0xFFFFFFFF^2 mod 2^32 = 1, engine delay 1
        eng_d = 1;
        a = '0;
        a[31:0] = 32'hFFFF_FFFF;
        e = '0;
        e[31:0] = 32'd1;
        start_job("wrap", a, a);
        finish_job("wrap", e, 1'b0, 49);

        // engine hangs on the 6th dot product -> abort with partial C
        eng_d    = 3;
        hang_idx = 5;
        e = '0;
        for (int k = 0; k < 5; k++) e[32*k +: 32] = 32'(k + 1);
        start_job("tmo", mat_ident(), mat_seq());
        finish_job("tmo", e, 1'b1, 0);
        hang_idx = -1;
        start_job("after_tmo", mat_fill(32'd2), mat_fill(32'd3));
        finish_job("after_tmo", mat_fill(32'd24), 1'b0, 81);

        // back-pressure: job_valid pulses during the job, C held in OUT
        start_job("bp", mat_ident(), mat_seq());
        a_matrix   = mat_fill(32'd2);
        b_matrix   = mat_fill(32'd3);
        jr_bad     = 1'b0;
        stable_bad = 1'b0;
        ok         = 1'b0;
        for (int t = 0; t < 3000; t++) begin
            job_valid = t[2];
            c_ready   = (t == 10);
            @(posedge clk); #1;
            if (job_ready) jr_bad = 1'b1;
            if (c_valid) begin
                ok = 1'b1;
                break;
            end
        end
        c_ready   = 1'b0;
        job_valid = 1'b1;
        chk("bp_cvalid", 512'(ok), 512'(1));
        cm = c_matrix;
        for (int t = 0; t < 10; t++) begin
            @(posedge clk); #1;
            if (c_matrix !== cm || !c_valid) stable_bad = 1'b1;
            if (job_ready) jr_bad = 1'b1;
        end
        chk("bp_job_ready_low", 512'(jr_bad), 512'(0));
        chk("bp_c_stable", 512'(stable_bad), 512'(0));
        chk("bp_cmatrix", c_matrix, mat_seq());
        c_ready = 1'b1;
        @(posedge clk); #1;
        c_ready = 1'b0;
        chk("bp_cvalid_drop", 512'(c_valid), 512'(0));
        chk("bp_ready_after_hs", 512'(job_ready), 512'(1));
        @(posedge clk); #1;
        job_valid = 1'b0;
        chk("bp_second_accepted", 512'(job_ready), 512'(0));
        finish_job("bp2", mat_fill(32'd24), 1'b0, 0);

        // reset in WAIT of the 7th dot product
        start_job("rstmid", mat_ident(), mat_seq());
        ok = 1'b0;
        for (int t = 0; t < 500; t++) begin
            @(posedge clk); #1;
            if (dp_start && eng_idx == 6) begin
                ok = 1'b1;
                break;
            end
        end
        chk("rstmid_reached", 512'(ok), 512'(1));
        #2;
        reset = 1'b1;
        #1;
        chk("rstmid_ctrl", 512'({job_ready, dp_start, dp_clr, c_valid, c_error}), 512'(0));
        chk("rstmid_cmat", c_matrix, '0);
        chk("rstmid_vecs", 512'({dp_vec_a, dp_vec_b}), '0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        wait_ready("rstmid_boot", 1'b1);
        start_job("rstmid_next", mat_ident(), mat_seq());
        finish_job("rstmid_next", mat_seq(), 1'b0, 81);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
